// File: rtl/excp_pkg.sv
// Shared types and constants for the EXU exception/trap controller.
// Flag bit i of the exception vector maps to EXCP_CAUSE[i]; a lower index means a higher priority.
package excp_pkg;

    localparam int CAUSE_W    = 5;
    localparam int MAX_SRC    = 8;
    localparam int IDX_W      = 3;
    localparam int EBREAK_IDX = 1;

    localparam logic [CAUSE_W-1:0] NO_CAUSE = 5'h1F;

    // Index 0 is the rightmost entry:
    // illegal, ebreak, ecall_m, ld_misalign, st_misalign, inst_misalign, ld_fault, st_fault.
    localparam logic [MAX_SRC-1:0][CAUSE_W-1:0] EXCP_CAUSE = {
        5'd7, 5'd5, 5'd0, 5'd6, 5'd4, 5'd11, 5'd3, 5'd2
    };

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        COMMIT,
        HALT
    } state_e;

endpackage

// File: rtl/excp_prio_enc.sv
// Fixed-priority encoder for the exception flags. The lowest set index wins.
module excp_prio_enc
    import excp_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]  flags_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        any_o = |flags_i;
        idx_o = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (flags_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/exu_excp_ctrl.sv
// Commit-stage trap controller. It accepts one faulting instruction, flushes the pipeline,
// then records mepc/mcause/mtval and pulses commit_trap. Optionally, ebreak halts with an end code.
module exu_excp_ctrl
    import excp_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NSRC           = 4,
    parameter int HALT_ON_EBREAK = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             excp_i_valid,
    output logic             excp_i_ready,
    input  logic [NSRC-1:0]  excp_i_flags,
    input  logic [XLEN-1:0]  excp_i_pc,
    input  logic [XLEN-1:0]  excp_i_tval,
    input  logic [XLEN-1:0]  excp_i_a0,
    output logic             flush_req,
    input  logic             flush_ack,
    output logic             commit_trap,
    output logic [XLEN-1:0]  cmt_cause,
    output logic [XLEN-1:0]  cmt_epc,
    output logic [XLEN-1:0]  cmt_tval,
    output logic             halt,
    output logic [XLEN-1:0]  endcode,
    output logic [CNT_W-1:0] trap_cnt
);

    state_e             state_q;
    logic [NSRC-1:0]    flags_gated;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               accept;

    logic [CAUSE_W-1:0] cause_lat_q;
    logic               ebreak_lat_q;
    logic [XLEN-1:0]    pc_lat_q;
    logic [XLEN-1:0]    tval_lat_q;
    logic [XLEN-1:0]    a0_lat_q;

    logic               commit_trap_q;
    logic [CAUSE_W-1:0] cmt_cause_q;
    logic [XLEN-1:0]    cmt_epc_q;
    logic [XLEN-1:0]    cmt_tval_q;
    logic               halt_q;
    logic [XLEN-1:0]    endcode_q;
    logic [CNT_W-1:0]   trap_cnt_q;

    // Flags are qualified by valid so that don't-care flags can never start a trap.
    assign flags_gated = excp_i_valid ? excp_i_flags : '0;

    excp_prio_enc #(.NSRC(NSRC)) u_prio_enc (
        .flags_i (flags_gated),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    assign excp_i_ready = (state_q == IDLE);
    assign flush_req    = (state_q == FLUSH);
    assign accept       = excp_i_ready && pick_any;

    // NOTE: the capture registers are deliberately not reset. They are only read after a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            cause_lat_q  <= EXCP_CAUSE[pick_idx];
            ebreak_lat_q <= (pick_idx == IDX_W'(EBREAK_IDX));
            pc_lat_q     <= excp_i_pc;
            tval_lat_q   <= excp_i_tval;
            a0_lat_q     <= excp_i_a0;
        end
    end

    // NOTE: all state in a clocked block uses non-blocking assignments, so that every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            commit_trap_q <= 1'b0;
            cmt_cause_q   <= NO_CAUSE;
            cmt_epc_q     <= '0;
            cmt_tval_q    <= '0;
            halt_q        <= 1'b0;
            endcode_q     <= '0;
            trap_cnt_q    <= '0;
        end else begin
            commit_trap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (flush_ack) begin
                        commit_trap_q <= 1'b1;
                        cmt_cause_q   <= cause_lat_q;
                        cmt_epc_q     <= pc_lat_q;
                        cmt_tval_q    <= tval_lat_q;
                        if (trap_cnt_q != {CNT_W{1'b1}}) trap_cnt_q <= trap_cnt_q + CNT_W'(1);
                        if (ebreak_lat_q && (HALT_ON_EBREAK != 0)) begin
                            state_q   <= HALT;
                            halt_q    <= 1'b1;
                            endcode_q <= a0_lat_q;
                        end else begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT:  state_q <= IDLE;
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign commit_trap = commit_trap_q;
    assign cmt_cause   = {{(XLEN - CAUSE_W){1'b0}}, cmt_cause_q};
    assign cmt_epc     = cmt_epc_q;
    assign cmt_tval    = cmt_tval_q;
    assign halt        = halt_q;
    assign endcode     = endcode_q;
    assign trap_cnt    = trap_cnt_q;

    a_flags_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(flags_gated));

endmodule
